// File: rtl/slot_spin_if.sv
// Player/RNG-facing signal bundle of the slot machine game sequencer.
// master drives the player inputs and reel values; slave is the sequencer itself.
interface slot_spin_if #(
   parameter int unsigned CREDIT_W = 8
);
   logic                coin_in;
   logic                spin_req;
   logic [2:0]          reel1;
   logic [2:0]          reel2;
   logic [2:0]          reel3;
   logic                reel_en;
   logic [CREDIT_W-1:0] credits;
   logic                busy;
   logic                spin_reject;
   logic                result_valid;
   logic [1:0]          win_class;
   logic [7:0]          payout;
   logic                free_spin;

   modport master (
      output coin_in, spin_req, reel1, reel2, reel3,
      input  reel_en, credits, busy, spin_reject, result_valid, win_class, payout, free_spin
   );

   modport slave (
      input  coin_in, spin_req, reel1, reel2, reel3,
      output reel_en, credits, busy, spin_reject, result_valid, win_class, payout, free_spin
   );
endinterface

// File: rtl/slot_spin_controller.sv
// Slot machine game sequencer: credit tracking, spin acceptance, reel RNG enable, scoring, payout.
// Optional feature macro FREE_SPIN_EN: a jackpot grants one free (unpaid, never rejected) spin.
module slot_spin_controller #(
   parameter int unsigned CREDIT_W    = 8,
   parameter int unsigned MAX_CREDITS = 255,
   parameter int unsigned BET_COST    = 1,
   parameter int unsigned SPIN_CYCLES = 12,
   parameter int unsigned PAIR_PAY    = 2,
   parameter int unsigned TRIPLE_PAY  = 5,
   parameter int unsigned JACKPOT_PAY = 20
) (
   input logic        clk,
   input logic        reset,
   slot_spin_if.slave bus
);

   localparam int unsigned SumW = CREDIT_W + 2;
   localparam int unsigned CntW = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StSpin,
      StSettle,
      StEval,
      StPayout
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     spin_cnt_q, spin_cnt_d;
   logic [7:0]          pay_cnt_q, pay_cnt_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic [1:0]          win_class_q, win_class_d;
   logic [7:0]          payout_q, payout_d;
   logic                result_valid_q, result_valid_d;
   logic                spin_reject_q, spin_reject_d;
   logic                free_pending;

   // Scoring of the current reel values
   logic                eq12, eq13, eq23;
   logic [1:0]          score_class;
   logic [7:0]          score_pay;

   // Credit arithmetic, wide and signed so the clamp sees true over/underflow
   logic signed [SumW-1:0] add_coin, add_step, sub_bet, credit_sum;

`ifdef FREE_SPIN_EN
   logic free_spin_q, free_spin_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         free_spin_q <= 1'b0;
      end else begin
         free_spin_q <= free_spin_d;
      end
   end

   assign free_pending = free_spin_q;
`else
   assign free_pending = 1'b0;
`endif

   always_comb begin
      eq12 = (bus.reel1 == bus.reel2);
      eq13 = (bus.reel1 == bus.reel3);
      eq23 = (bus.reel2 == bus.reel3);
      if (eq12 && eq13) begin
         if (bus.reel1 == 3'd7) begin
            score_class = 2'd3;
            score_pay   = 8'(JACKPOT_PAY);
         end else begin
            score_class = 2'd2;
            score_pay   = 8'(TRIPLE_PAY);
         end
      end else if (eq12 || eq13 || eq23) begin
         score_class = 2'd1;
         score_pay   = 8'(PAIR_PAY);
      end else begin
         score_class = 2'd0;
         score_pay   = 8'd0;
      end
   end

   always_comb begin
      state_d        = state_q;
      spin_cnt_d     = spin_cnt_q;
      pay_cnt_d      = pay_cnt_q;
      win_class_d    = win_class_q;
      payout_d       = payout_q;
      result_valid_d = 1'b0;
      spin_reject_d  = 1'b0;
      add_coin       = '0;
      add_step       = '0;
      sub_bet        = '0;
      credits_d      = credits_q;
`ifdef FREE_SPIN_EN
      free_spin_d    = free_spin_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.spin_req) begin
               if (free_pending) begin
                  state_d    = StSpin;
                  spin_cnt_d = CntW'(SPIN_CYCLES - 1);
`ifdef FREE_SPIN_EN
                  free_spin_d = 1'b0;
`endif
               end else if ({2'b00, credits_q} >= SumW'(BET_COST)) begin
                  state_d    = StSpin;
                  spin_cnt_d = CntW'(SPIN_CYCLES - 1);
                  sub_bet    = SumW'(BET_COST);
               end else begin
                  spin_reject_d = 1'b1;
               end
            end
         end
         StSpin: begin
            if (spin_cnt_q == '0) begin
               state_d = StSettle;
            end else begin
               spin_cnt_d = spin_cnt_q - CntW'(1);
            end
         end
         StSettle: begin
            // Reels are frozen once reel_en drops; capturing on this edge makes the new score
            // and result_valid appear together in the EVAL cycle.
            state_d        = StEval;
            win_class_d    = score_class;
            payout_d       = score_pay;
            pay_cnt_d      = score_pay;
            result_valid_d = 1'b1;
`ifdef FREE_SPIN_EN
            if (score_class == 2'd3) begin
               free_spin_d = 1'b1;
            end
`endif
         end
         StEval: begin
            state_d = (payout_q != 8'd0) ? StPayout : StIdle;
         end
         StPayout: begin
            add_step  = SumW'(1);
            pay_cnt_d = pay_cnt_q - 8'd1;
            if (pay_cnt_q == 8'd1) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (bus.coin_in) begin
         add_coin = SumW'(1);
      end
      credit_sum = $signed({2'b00, credits_q}) + add_coin + add_step - sub_bet;
      if (credit_sum < 0) begin
         credits_d = '0;
      end else if (credit_sum > $signed(SumW'(MAX_CREDITS))) begin
         credits_d = CREDIT_W'(MAX_CREDITS);
      end else begin
         credits_d = credit_sum[CREDIT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         spin_cnt_q     <= '0;
         pay_cnt_q      <= 8'd0;
         credits_q      <= '0;
         win_class_q    <= 2'd0;
         payout_q       <= 8'd0;
         result_valid_q <= 1'b0;
         spin_reject_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         spin_cnt_q     <= spin_cnt_d;
         pay_cnt_q      <= pay_cnt_d;
         credits_q      <= credits_d;
         win_class_q    <= win_class_d;
         payout_q       <= payout_d;
         result_valid_q <= result_valid_d;
         spin_reject_q  <= spin_reject_d;
      end
   end

   // Decoded from the state register so reset drops reel_en without waiting for a clock
   assign bus.reel_en      = (state_q == StSpin);
   assign bus.busy         = (state_q != StIdle);
   assign bus.credits      = credits_q;
   assign bus.spin_reject  = spin_reject_q;
   assign bus.result_valid = result_valid_q;
   assign bus.win_class    = win_class_q;
   assign bus.payout       = payout_q;
   assign bus.free_spin    = free_pending;

endmodule
